// File: rtl/mem_stage_if.sv
// EX/WB/data-SRAM signal bundle of the MEM stage; master is the stage itself,
// slave is whatever surrounds it (EX, WB and the data SRAM port).
interface mem_stage_if;
    logic        left_valid;
    logic        left_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_inst;
    logic [31:0] ex_result;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_mem_op;
    logic        ex_wreg_en;
    logic [4:0]  ex_wreg_index;
    logic        ex_is_break;
    logic [10:0] ex_excp_bus;
    logic        flush;
    logic        right_valid;
    logic        right_ready;
    logic [103:0] mem_ctrl_bus;
    logic [10:0] mem_excp_bus;
    logic [37:0] mem_bypass;
    logic        mem_load_pending;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;

    modport master (
        input  left_valid, ex_pc, ex_inst, ex_result, ex_wdata, ex_mem_op, ex_wreg_en,
               ex_wreg_index, ex_is_break, ex_excp_bus, flush, right_ready,
               data_addr_ok, data_rdata, data_data_ok,
        output left_ready, right_valid, mem_ctrl_bus, mem_excp_bus, mem_bypass,
               mem_load_pending, data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata
    );

    modport slave (
        output left_valid, ex_pc, ex_inst, ex_result, ex_wdata, ex_mem_op, ex_wreg_en,
               ex_wreg_index, ex_is_break, ex_excp_bus, flush, right_ready,
               data_addr_ok, data_rdata, data_data_ok,
        input  left_ready, right_valid, mem_ctrl_bus, mem_excp_bus, mem_bypass,
               mem_load_pending, data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues split-transaction SRAM load/store, formats load data, hands off to WB.
// Latency: non-mem op 1 cycle to WB-visible, mem op >= 3 cycles (REQ, WAIT, DONE).
// Backpressure: holds DONE while right_ready=0; MEM_ALE_CHECK_EN adds misalignment exceptions.
module mem_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, CANCEL} state_t;

    localparam logic [3:0] OP_LD_B  = 4'd1;
    localparam logic [3:0] OP_LD_H  = 4'd2;
    localparam logic [3:0] OP_LD_W  = 4'd3;
    localparam logic [3:0] OP_ST_B  = 4'd4;
    localparam logic [3:0] OP_ST_H  = 4'd5;
    localparam logic [3:0] OP_ST_W  = 4'd6;
    localparam logic [3:0] OP_LD_BU = 4'd7;
    localparam logic [3:0] OP_LD_HU = 4'd8;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op == OP_LD_B) || (op == OP_LD_H) || (op == OP_LD_W) ||
               (op == OP_LD_BU) || (op == OP_LD_HU);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == OP_ST_B) || (op == OP_ST_H) || (op == OP_ST_W);
    endfunction

    state_t      state_q, state_d;
    logic [31:0] pc_q, inst_q, result_q, wdata_q;
    logic [3:0]  op_q;
    logic        wreg_en_q, is_break_q;
    logic [4:0]  wreg_index_q;
    logic [10:0] excp_q;

    logic        in_store, in_mem, in_misalign, issue, left_ready_int, capture;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_fmt, st_wdata;
    logic [3:0]  st_wstrb;
    logic [1:0]  st_size;

    assign in_store = op_is_store(bus.ex_mem_op);
    assign in_mem   = op_is_load(bus.ex_mem_op) | in_store;

`ifdef MEM_ALE_CHECK_EN
    always_comb begin
        in_misalign = 1'b0;
        case (bus.ex_mem_op)
            OP_LD_H, OP_LD_HU, OP_ST_H: in_misalign = bus.ex_result[0];
            OP_LD_W, OP_ST_W:           in_misalign = |bus.ex_result[1:0];
            default:                    in_misalign = 1'b0;
        endcase
    end
`else
    assign in_misalign = 1'b0;
`endif

    // Excepted or misaligned instructions bypass the SRAM and go straight to DONE.
    assign issue          = in_mem & ~bus.ex_excp_bus[0] & ~in_misalign;
    assign left_ready_int = ~bus.flush & ((state_q == IDLE) | ((state_q == DONE) & bus.right_ready));
    assign capture        = bus.left_valid & left_ready_int;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (capture) state_d = issue ? REQ : DONE;
            end
            REQ: begin
                // An accepted request must still be drained even if flushed.
                if (bus.flush)             state_d = bus.data_addr_ok ? CANCEL : IDLE;
                else if (bus.data_addr_ok) state_d = WAIT;
            end
            WAIT: begin
                if (bus.data_data_ok) state_d = bus.flush ? IDLE : DONE;
                else if (bus.flush)   state_d = CANCEL;
            end
            DONE: begin
                if (bus.flush)            state_d = IDLE;
                else if (bus.right_ready) state_d = capture ? (issue ? REQ : DONE) : IDLE;
            end
            CANCEL: begin
                if (bus.data_data_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0;
            result_q     <= 32'h0;
            wdata_q      <= 32'h0;
            op_q         <= 4'h0;
            wreg_en_q    <= 1'b0;
            wreg_index_q <= 5'h0;
            is_break_q   <= 1'b0;
            excp_q       <= 11'h0;
        end else if (capture) begin
            pc_q         <= bus.ex_pc;
            inst_q       <= bus.ex_inst;
            result_q     <= bus.ex_result;
            wdata_q      <= bus.ex_wdata;
            op_q         <= bus.ex_mem_op;
            wreg_en_q    <= bus.ex_wreg_en & ~in_store & ~in_misalign;
            wreg_index_q <= bus.ex_wreg_index;
            is_break_q   <= bus.ex_is_break;
            excp_q       <= {bus.ex_excp_bus[10:1], bus.ex_excp_bus[0] | in_misalign};
        end else if ((state_q == WAIT) && bus.data_data_ok && op_is_load(op_q)) begin
            result_q     <= load_fmt;
        end
    end

    always_comb begin
        rd_byte = bus.data_rdata[7:0];
        case (result_q[1:0])
            2'd1:    rd_byte = bus.data_rdata[15:8];
            2'd2:    rd_byte = bus.data_rdata[23:16];
            2'd3:    rd_byte = bus.data_rdata[31:24];
            default: rd_byte = bus.data_rdata[7:0];
        endcase
        rd_half = result_q[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
        case (op_q)
            OP_LD_B:  load_fmt = {{24{rd_byte[7]}}, rd_byte};
            OP_LD_BU: load_fmt = {24'h0, rd_byte};
            OP_LD_H:  load_fmt = {{16{rd_half[15]}}, rd_half};
            OP_LD_HU: load_fmt = {16'h0, rd_half};
            default:  load_fmt = bus.data_rdata;
        endcase
    end

    always_comb begin
        st_size  = 2'd2;
        st_wstrb = 4'h0;
        st_wdata = 32'h0;
        case (op_q)
            OP_LD_B, OP_LD_BU: st_size = 2'd0;
            OP_LD_H, OP_LD_HU: st_size = 2'd1;
            OP_ST_B: begin
                st_size  = 2'd0;
                st_wstrb = 4'b0001 << result_q[1:0];
                st_wdata = {4{wdata_q[7:0]}};
            end
            OP_ST_H: begin
                st_size  = 2'd1;
                st_wstrb = result_q[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{wdata_q[15:0]}};
            end
            OP_ST_W: begin
                st_wstrb = 4'hF;
                st_wdata = wdata_q;
            end
            default: st_size = 2'd2;
        endcase
    end

    assign bus.left_ready       = left_ready_int;
    assign bus.right_valid      = (state_q == DONE);
    assign bus.mem_ctrl_bus     = {is_break_q, bus.right_valid, wreg_index_q, wreg_en_q,
                                   inst_q, pc_q, result_q};
    assign bus.mem_excp_bus     = excp_q;
    assign bus.mem_bypass       = {result_q, wreg_index_q, wreg_en_q & (state_q == DONE)};
    assign bus.mem_load_pending = op_is_load(op_q) & ((state_q == REQ) | (state_q == WAIT));

    assign bus.data_req   = (state_q == REQ);
    assign bus.data_wr    = bus.data_req & op_is_store(op_q);
    assign bus.data_size  = bus.data_req ? st_size  : 2'd0;
    assign bus.data_wstrb = bus.data_req ? st_wstrb : 4'h0;
    assign bus.data_addr  = bus.data_req ? result_q : 32'h0;
    assign bus.data_wdata = bus.data_req ? st_wdata : 32'h0;
endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed bench for mem_stage against a behavioural reference model.
module tb_mem_stage;
    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    mem_stage_if bus();
    mem_stage #(.RESET_PC(RESET_PC)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic bit m_is_load(input int op);
        return op == 1 || op == 2 || op == 3 || op == 7 || op == 8;
    endfunction
    function automatic bit m_is_store(input int op);
        return op >= 4 && op <= 6;
    endfunction
    function automatic bit m_misaligned(input int op, input logic [31:0] a);
        bit ale = 1'b0;
`ifdef MEM_ALE_CHECK_EN
        ale = 1'b1;
`endif
        if (!ale) return 1'b0;
        if (op == 2 || op == 5 || op == 8) return (a % 2) != 0;
        if (op == 3 || op == 6) return (a % 4) != 0;
        return 1'b0;
    endfunction
    function automatic logic [31:0] m_load(input int op, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> ((a % 4) * 8)) & 32'hFF;
        h = (rd >> (((a / 2) % 2) * 16)) & 32'hFFFF;
        case (op)
            1: return (b >= 128) ? b + 32'hFFFFFF00 : b;
            7: return b;
            2: return (h >= 32768) ? h + 32'hFFFF0000 : h;
            8: return h;
            default: return rd;
        endcase
    endfunction
    function automatic logic [3:0] m_wstrb(input int op, input logic [31:0] a);
        case (op)
            4: return 4'(1 << (a % 4));
            5: return ((a / 2) % 2) ? 4'd12 : 4'd3;
            6: return 4'd15;
            default: return 4'd0;
        endcase
    endfunction
    function automatic logic [31:0] m_wdata(input int op, input logic [31:0] w);
        case (op)
            4: return (w & 32'hFF) * 32'h01010101;
            5: return (w & 32'hFFFF) * 32'h00010001;
            default: return w;
        endcase
    endfunction
    function automatic logic [1:0] m_size(input int op);
        if (op == 1 || op == 4 || op == 7) return 2'd0;
        if (op == 2 || op == 5 || op == 8) return 2'd1;
        return 2'd2;
    endfunction

    // ---------------- drivers ----------------
    task automatic init_inputs();
        bus.left_valid = 0; bus.ex_pc = 0; bus.ex_inst = 0; bus.ex_result = 0; bus.ex_wdata = 0;
        bus.ex_mem_op = 0; bus.ex_wreg_en = 0; bus.ex_wreg_index = 0; bus.ex_is_break = 0;
        bus.ex_excp_bus = 0; bus.flush = 0; bus.right_ready = 1; bus.data_addr_ok = 0;
        bus.data_rdata = 0; bus.data_data_ok = 0;
    endtask

    task automatic drive_ex(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        bus.ex_mem_op = op; bus.ex_result = addr; bus.ex_wdata = wdata;
        bus.ex_pc = $urandom; bus.ex_inst = $urandom; bus.ex_wreg_en = 1'b1;
        bus.ex_wreg_index = 5'($urandom); bus.ex_is_break = 1'b0; bus.ex_excp_bus = 11'h0;
    endtask

    // Presents the current ex_* fields and waits for the capture edge.
    task automatic launch();
        bus.left_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.left_valid = 1'b0;
    endtask

    task automatic do_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic [31:0] pc, input logic [31:0] inst,
                          input logic wen, input logic [4:0] idx, input logic brk,
                          input logic [10:0] excp, input int addr_dly, input int data_dly,
                          output logic [103:0] ctrl, output logic [10:0] excp_o,
                          output logic [37:0] byp, output int lat, output int nreq,
                          output logic [3:0] wstrb, output logic [31:0] raddr,
                          output logic [31:0] rwdata, output logic [1:0] size,
                          output logic wr, output logic pend);
        int  wait_a, wait_d;
        bit  accepted, done;
        wait_a = 0; wait_d = 0; accepted = 0; done = 0;
        ctrl = '0; excp_o = '0; byp = '0; lat = 0; nreq = 0;
        wstrb = '0; raddr = '0; rwdata = '0; size = '0; wr = 0; pend = 0;
        bus.ex_mem_op = op; bus.ex_result = addr; bus.ex_wdata = wdata; bus.ex_pc = pc;
        bus.ex_inst = inst; bus.ex_wreg_en = wen; bus.ex_wreg_index = idx;
        bus.ex_is_break = brk; bus.ex_excp_bus = excp;
        launch();
        for (int c = 0; c < 60 && !done; c++) begin
            lat++;
            @(negedge clk);
            if (bus.right_valid) begin
                ctrl = bus.mem_ctrl_bus; excp_o = bus.mem_excp_bus; byp = bus.mem_bypass;
                done = 1;
            end else if (bus.data_req) begin
                if (nreq == 0) begin
                    wstrb = bus.data_wstrb; raddr = bus.data_addr; rwdata = bus.data_wdata;
                    size = bus.data_size; wr = bus.data_wr; pend = bus.mem_load_pending;
                end
                nreq++;
                if (wait_a >= addr_dly) begin bus.data_addr_ok = 1'b1; accepted = 1; end
                else wait_a++;
            end else if (accepted) begin
                if (wait_d >= data_dly) begin
                    bus.data_data_ok = 1'b1; bus.data_rdata = rdata; accepted = 0;
                end else wait_d++;
            end
            @(posedge clk); #1;
            bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = $urandom;
        end
        if (!done) lat = -1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [103:0] exp_ctrl;
        exp_ctrl = '0;
        exp_ctrl[63:32] = RESET_PC;
        init_inputs();
        reset = 1'b0;
        #12;
        checks++; if (bus.left_ready !== 1'b1) begin failures++; $display("FAIL reset_left_ready got=%b exp=1", bus.left_ready); end
        checks++; if (bus.right_valid !== 1'b0) begin failures++; $display("FAIL reset_right_valid got=%b exp=0", bus.right_valid); end
        checks++; if (bus.mem_ctrl_bus !== exp_ctrl) begin failures++; $display("FAIL reset_ctrl got=%h exp=%h", bus.mem_ctrl_bus, exp_ctrl); end
        checks++; if ({bus.mem_excp_bus, bus.mem_bypass, bus.mem_load_pending} !== 50'h0) begin failures++; $display("FAIL reset_side_buses got=%h/%h/%b exp=0", bus.mem_excp_bus, bus.mem_bypass, bus.mem_load_pending); end
        checks++; if ({bus.data_req, bus.data_wr, bus.data_size, bus.data_wstrb, bus.data_addr, bus.data_wdata} !== 72'h0) begin failures++; $display("FAIL reset_sram got req=%b addr=%h exp=0", bus.data_req, bus.data_addr); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_word();
        logic [103:0] ctrl; logic [10:0] ex; logic [37:0] byp; int lat, nreq;
        logic [3:0] ws; logic [31:0] ra, rw; logic [1:0] sz; logic wr, pend;
        logic [31:0] pc, inst;
        pc = $urandom; inst = $urandom;
        do_txn(4'd3, 32'h1000, 32'h0, 32'hDEADBEEF, pc, inst, 1'b1, 5'd7, 1'b0, 11'h0, 0, 0,
               ctrl, ex, byp, lat, nreq, ws, ra, rw, sz, wr, pend);
        checks++; if (ctrl !== {1'b0, 1'b1, 5'd7, 1'b1, inst, pc, 32'hDEADBEEF}) begin failures++; $display("FAIL ldw_ctrl got=%h", ctrl); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL ldw_latency got=%0d exp=3", lat); end
        checks++; if ({ra, sz, wr, ws} !== {32'h1000, 2'd2, 1'b0, 4'h0}) begin failures++; $display("FAIL ldw_req got addr=%h size=%0d wr=%b wstrb=%b", ra, sz, wr, ws); end
        checks++; if (pend !== 1'b1) begin failures++; $display("FAIL ldw_pending got=%b exp=1", pend); end
        checks++; if (byp !== {32'hDEADBEEF, 5'd7, 1'b1}) begin failures++; $display("FAIL ldw_bypass got=%h", byp); end
    endtask

    task automatic test_load_byte();
        logic [103:0] ctrl; logic [10:0] ex; logic [37:0] byp; int lat, nreq;
        logic [3:0] ws; logic [31:0] ra, rw; logic [1:0] sz; logic wr, pend;
        do_txn(4'd1, 32'h1003, 32'h0, 32'h80112233, 32'h0, 32'h0, 1'b1, 5'd3, 1'b0, 11'h0, 1, 2,
               ctrl, ex, byp, lat, nreq, ws, ra, rw, sz, wr, pend);
        checks++; if (ctrl[31:0] !== 32'hFFFFFF80) begin failures++; $display("FAIL ldb_result got=%h exp=ffffff80", ctrl[31:0]); end
        checks++; if (lat !== 6 || nreq !== 2) begin failures++; $display("FAIL ldb_timing got lat=%0d nreq=%0d exp 6/2", lat, nreq); end
        do_txn(4'd7, 32'h1003, 32'h0, 32'h80112233, 32'h0, 32'h0, 1'b1, 5'd3, 1'b0, 11'h0, 0, 0,
               ctrl, ex, byp, lat, nreq, ws, ra, rw, sz, wr, pend);
        checks++; if (ctrl[31:0] !== 32'h00000080) begin failures++; $display("FAIL ldbu_result got=%h exp=00000080", ctrl[31:0]); end
        checks++; if (sz !== 2'd0) begin failures++; $display("FAIL ldbu_size got=%0d exp=0", sz); end
    endtask

    task automatic test_store_half();
        logic [103:0] ctrl; logic [10:0] ex; logic [37:0] byp; int lat, nreq;
        logic [3:0] ws; logic [31:0] ra, rw; logic [1:0] sz; logic wr, pend;
        do_txn(4'd5, 32'h2002, 32'h00001234, 32'h0, 32'h0, 32'h0, 1'b1, 5'd9, 1'b0, 11'h0, 0, 1,
               ctrl, ex, byp, lat, nreq, ws, ra, rw, sz, wr, pend);
        checks++; if (ws !== 4'b1100) begin failures++; $display("FAIL sth_wstrb got=%b exp=1100", ws); end
        checks++; if (rw !== 32'h12341234) begin failures++; $display("FAIL sth_wdata got=%h exp=12341234", rw); end
        checks++; if ({wr, sz, pend} !== {1'b1, 2'd1, 1'b0}) begin failures++; $display("FAIL sth_req got wr=%b size=%0d pend=%b", wr, sz, pend); end
        checks++; if (ctrl[96] !== 1'b0 || byp[0] !== 1'b0) begin failures++; $display("FAIL sth_wreg_en got=%b fwd=%b exp=0", ctrl[96], byp[0]); end
        checks++; if (ctrl[31:0] !== 32'h2002) begin failures++; $display("FAIL sth_result got=%h exp=2002", ctrl[31:0]); end
    endtask

    task automatic test_no_request();
        logic [103:0] ctrl; logic [10:0] ex; logic [37:0] byp; int lat, nreq;
        logic [3:0] ws; logic [31:0] ra, rw; logic [1:0] sz; logic wr, pend;
        do_txn(4'd0, 32'hCAFE0001, 32'h0, 32'h0, 32'h10, 32'h20, 1'b1, 5'd1, 1'b1, 11'h0, 0, 0,
               ctrl, ex, byp, lat, nreq, ws, ra, rw, sz, wr, pend);
        checks++; if (lat !== 1 || nreq !== 0) begin failures++; $display("FAIL alu_timing got lat=%0d nreq=%0d exp 1/0", lat, nreq); end
        checks++; if (ctrl !== {1'b1, 1'b1, 5'd1, 1'b1, 32'h20, 32'h10, 32'hCAFE0001}) begin failures++; $display("FAIL alu_ctrl got=%h", ctrl); end
        do_txn(4'd3, 32'h3000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd2, 1'b0, 11'h4A5, 0, 0,
               ctrl, ex, byp, lat, nreq, ws, ra, rw, sz, wr, pend);
        checks++; if (nreq !== 0 || lat !== 1) begin failures++; $display("FAIL excp_noreq got nreq=%0d lat=%0d exp 0/1", nreq, lat); end
        checks++; if (ex !== 11'h4A5) begin failures++; $display("FAIL excp_passthru got=%h exp=4a5", ex); end
    endtask

    task automatic test_flush_wait();
        drive_ex(4'd3, 32'h4000, 32'h0);
        launch();
        @(negedge clk); bus.data_addr_ok = 1'b1;
        @(posedge clk); #1; bus.data_addr_ok = 1'b0;
        bus.flush = 1'b1;
        @(negedge clk);
        checks++; if (bus.left_ready !== 1'b0) begin failures++; $display("FAIL flush_wait_ready got=%b exp=0", bus.left_ready); end
        @(posedge clk); #1; bus.flush = 1'b0;
        drive_ex(4'd0, 32'h5555AAAA, 32'h0);
        bus.left_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({bus.left_ready, bus.right_valid, bus.data_req, bus.mem_load_pending} !== 4'b0) begin failures++; $display("FAIL cancel_outputs cyc=%0d got rdy=%b vld=%b req=%b pend=%b exp=0", i, bus.left_ready, bus.right_valid, bus.data_req, bus.mem_load_pending); end
            @(posedge clk); #1;
        end
        @(negedge clk); bus.data_data_ok = 1'b1;
        @(posedge clk); #1; bus.data_data_ok = 1'b0;
        @(negedge clk);
        checks++; if (bus.left_ready !== 1'b1) begin failures++; $display("FAIL cancel_exit_ready got=%b exp=1", bus.left_ready); end
        @(posedge clk); #1; bus.left_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.right_valid !== 1'b1 || bus.mem_ctrl_bus[31:0] !== 32'h5555AAAA) begin failures++; $display("FAIL post_cancel_capture got vld=%b res=%h exp 1/5555aaaa", bus.right_valid, bus.mem_ctrl_bus[31:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_req();
        drive_ex(4'd3, 32'h6000, 32'h0);
        launch();
        bus.flush = 1'b1;
        @(negedge clk);
        checks++; if (bus.data_req !== 1'b1 || bus.left_ready !== 1'b0) begin failures++; $display("FAIL flush_req_cycle got req=%b rdy=%b exp 1/0", bus.data_req, bus.left_ready); end
        @(posedge clk); #1; bus.flush = 1'b0;
        @(negedge clk);
        checks++; if (bus.left_ready !== 1'b1 || bus.data_req !== 1'b0) begin failures++; $display("FAIL flush_req_idle got rdy=%b req=%b exp 1/0", bus.left_ready, bus.data_req); end
        @(posedge clk); #1;
        drive_ex(4'd6, 32'h6004, 32'h11223344);
        launch();
        bus.flush = 1'b1;
        @(negedge clk); bus.data_addr_ok = 1'b1;
        @(posedge clk); #1; bus.flush = 1'b0; bus.data_addr_ok = 1'b0;
        @(negedge clk);
        checks++; if ({bus.left_ready, bus.right_valid, bus.data_req} !== 3'b000) begin failures++; $display("FAIL flush_req_addr_ok got rdy=%b vld=%b req=%b exp 000", bus.left_ready, bus.right_valid, bus.data_req); end
        bus.data_data_ok = 1'b1;
        @(posedge clk); #1; bus.data_data_ok = 1'b0;
        @(negedge clk);
        checks++; if (bus.left_ready !== 1'b1) begin failures++; $display("FAIL flush_req_drain got rdy=%b exp=1", bus.left_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [103:0] exp1;
        drive_ex(4'd0, 32'hA1A1A1A1, 32'h0);
        exp1 = {1'b0, 1'b1, bus.ex_wreg_index, 1'b1, bus.ex_inst, bus.ex_pc, 32'hA1A1A1A1};
        launch();
        bus.right_ready = 1'b0;
        drive_ex(4'd0, 32'hB2B2B2B2, 32'h0);
        bus.left_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (bus.mem_ctrl_bus !== exp1 || bus.left_ready !== 1'b0) begin failures++; $display("FAIL stall_hold cyc=%0d got ctrl=%h rdy=%b exp ctrl=%h rdy=0", i, bus.mem_ctrl_bus, bus.left_ready, exp1); end
            @(posedge clk); #1;
        end
        bus.right_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.left_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready got=%b exp=1", bus.left_ready); end
        @(posedge clk); #1; bus.left_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.right_valid !== 1'b1 || bus.mem_ctrl_bus[31:0] !== 32'hB2B2B2B2) begin failures++; $display("FAIL back_to_back got vld=%b res=%h exp 1/b2b2b2b2", bus.right_valid, bus.mem_ctrl_bus[31:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_req();
        drive_ex(4'd3, 32'h7000, 32'h0);
        launch();
        @(negedge clk);
        checks++; if (bus.data_req !== 1'b1) begin failures++; $display("FAIL midreq_pre got req=%b exp=1", bus.data_req); end
        reset = 1'b0;
        #1;
        checks++; if (bus.data_req !== 1'b0 || bus.left_ready !== 1'b1 || bus.mem_ctrl_bus[63:32] !== RESET_PC) begin failures++; $display("FAIL midreq_reset got req=%b rdy=%b pc=%h", bus.data_req, bus.left_ready, bus.mem_ctrl_bus[63:32]); end
        #2; reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.data_req !== 1'b0 || bus.right_valid !== 1'b0) begin failures++; $display("FAIL midreq_after got req=%b vld=%b exp 0/0", bus.data_req, bus.right_valid); end
        @(posedge clk); #1;
    endtask

`ifdef MEM_ALE_CHECK_EN
    task automatic test_ale();
        logic [103:0] ctrl; logic [10:0] ex; logic [37:0] byp; int lat, nreq;
        logic [3:0] ws; logic [31:0] ra, rw; logic [1:0] sz; logic wr, pend;
        do_txn(4'd3, 32'h1002, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd4, 1'b0, 11'h0, 0, 0,
               ctrl, ex, byp, lat, nreq, ws, ra, rw, sz, wr, pend);
        checks++; if (nreq !== 0 || lat !== 1) begin failures++; $display("FAIL ale_noreq got nreq=%0d lat=%0d exp 0/1", nreq, lat); end
        checks++; if (ex[0] !== 1'b1 || ctrl[31:0] !== 32'h1002 || ctrl[96] !== 1'b0) begin failures++; $display("FAIL ale_fields got excp=%b res=%h wen=%b exp 1/1002/0", ex[0], ctrl[31:0], ctrl[96]); end
    endtask
`endif

    task automatic test_random();
        logic [103:0] ctrl, exp_ctrl; logic [10:0] ex, excp; logic [37:0] byp; int lat, nreq;
        logic [3:0] ws; logic [31:0] ra, rw; logic [1:0] sz; logic wr, pend;
        logic [31:0] addr, wdata, rdata, pc, inst, exp_res; logic wen, brk, exp_wen, issued, mis;
        logic [4:0] idx; int op, ad, dd, exp_lat;
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 10); addr = $urandom; wdata = $urandom; rdata = $urandom;
            pc = $urandom; inst = $urandom; wen = 1'($urandom); brk = 1'($urandom);
            idx = 5'($urandom); ad = $urandom_range(0, 3); dd = $urandom_range(0, 3);
            excp = 11'($urandom) & 11'h7FE;
            if ($urandom_range(0, 7) == 0) excp = excp | 11'h1;
            if ($urandom_range(0, 1) == 1) addr = addr & 32'hFFFFFFFC;
            do_txn(4'(op), addr, wdata, rdata, pc, inst, wen, idx, brk, excp, ad, dd,
                   ctrl, ex, byp, lat, nreq, ws, ra, rw, sz, wr, pend);
            mis     = m_misaligned(op, addr);
            issued  = (m_is_load(op) || m_is_store(op)) && excp[0] == 1'b0 && !mis;
            exp_lat = issued ? 3 + ad + dd : 1;
            exp_res = (issued && m_is_load(op)) ? m_load(op, addr, rdata) : addr;
            exp_wen = wen && !m_is_store(op) && !mis;
            exp_ctrl = {brk, 1'b1, idx, exp_wen, inst, pc, exp_res};
            checks++; if (ctrl !== exp_ctrl) begin failures++; $display("FAIL rnd_ctrl n=%0d op=%0d got=%h exp=%h", n, op, ctrl, exp_ctrl); end
            checks++; if (ex !== (excp | 11'(mis)) || byp !== {exp_res, idx, exp_wen}) begin failures++; $display("FAIL rnd_excp_byp n=%0d got=%h/%h", n, ex, byp); end
            checks++; if (lat !== exp_lat || nreq !== (issued ? ad + 1 : 0)) begin failures++; $display("FAIL rnd_timing n=%0d op=%0d got lat=%0d nreq=%0d exp lat=%0d", n, op, lat, nreq, exp_lat); end
            if (issued) begin
                checks++; if ({ra, sz, wr, ws, pend} !== {addr, m_size(op), 1'(m_is_store(op)), m_wstrb(op, addr), 1'(m_is_load(op))}) begin failures++; $display("FAIL rnd_req n=%0d op=%0d got addr=%h size=%0d wr=%b wstrb=%b pend=%b", n, op, ra, sz, wr, ws, pend); end
                if (m_is_store(op)) begin
                    checks++; if (rw !== m_wdata(op, wdata)) begin failures++; $display("FAIL rnd_wdata n=%0d op=%0d got=%h exp=%h", n, op, rw, m_wdata(op, wdata)); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_byte();
        test_store_half();
        test_no_request();
        test_flush_wait();
        test_flush_req();
        test_back_to_back();
        test_reset_mid_req();
`ifdef MEM_ALE_CHECK_EN
        test_ale();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
